rv32im_csr_reg_file: RTL and testbench

// - Machine-mode CSR register file for the rv32im core (Zicsr subset, M-mode only).
// - Decodes a 12-bit CSR address and provides combinational reads and clocked writes.
// - Runs the free-running 64-bit mcycle counter.
// - Exports mstatus and the current privilege level to the core.

---
 rtl/rv32im_csr_reg_file_pkg.sv | 50 +++++
 rtl/rv32im_csr_counter64.sv | 41 ++++
 rtl/rv32im_csr_reg_file.sv | 95 +++++++++
 tb/tb_rv32im_csr_reg_file.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32im_csr_reg_file_pkg.sv
// Shared CSR definitions for the rv32im machine-mode CSR block:
// widths, CSR addresses, write masks and privilege encodings.
package rv32im_csr_reg_file_pkg;

  localparam int API_XLEN  = 32;
  localparam int CSR_WIDTH = 12;

  typedef logic [API_XLEN-1:0]  xlen_t;
  typedef logic [CSR_WIDTH-1:0] csr_addr_t;

  // Machine information / trap setup / trap handling
  localparam csr_addr_t CSR_MSTATUS   = 12'h300;
  localparam csr_addr_t CSR_MISA      = 12'h301;
  localparam csr_addr_t CSR_MIE       = 12'h304;
  localparam csr_addr_t CSR_MTVEC     = 12'h305;
  localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
  localparam csr_addr_t CSR_MEPC      = 12'h341;
  localparam csr_addr_t CSR_MCAUSE    = 12'h342;
  localparam csr_addr_t CSR_MTVAL     = 12'h343;
  localparam csr_addr_t CSR_MIP       = 12'h344;
  // Counters
  localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
  localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
  localparam csr_addr_t CSR_CYCLE     = 12'hC00;
  localparam csr_addr_t CSR_CYCLEH    = 12'hC80;
  // Machine identification
  localparam csr_addr_t CSR_MVENDORID = 12'hF11;
  localparam csr_addr_t CSR_MARCHID   = 12'hF12;
  localparam csr_addr_t CSR_MIMPID    = 12'hF13;
  localparam csr_addr_t CSR_MHARTID   = 12'hF14;

  // Write masks: bits outside a mask are stored as zero
  localparam xlen_t MSTATUS_MASK     = 32'h0000_1888;
  localparam xlen_t MSTATUS_MPP_MASK = 32'h0000_1800;
  localparam xlen_t MIE_MASK         = 32'h0000_0888;
  localparam xlen_t MTVEC_MASK       = 32'hFFFF_FFFC;
  localparam xlen_t MEPC_MASK        = 32'hFFFF_FFFC;

  // Privilege encodings
  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_U = 2'b00;

  localparam xlen_t MSTATUS_RESET = {19'b0, PRIV_M, 11'b0};

  // Only machine mode exists, so MPP always holds M regardless of the written value
  function automatic xlen_t mstatus_warl(input xlen_t wdata);
    return (wdata & MSTATUS_MASK & ~MSTATUS_MPP_MASK) | {19'b0, PRIV_M, 11'b0};
  endfunction

endpackage

// File: rtl/rv32im_csr_counter64.sv
// 64-bit free-running counter built from two 32-bit words, each with its
// own write strobe. A write to either word suppresses the increment.
module rv32im_csr_counter64
  import rv32im_csr_reg_file_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  output logic [63:0] count
);

  logic [31:0] word_reg [2];
  logic [63:0] count_next;
  logic [1:0]  wr_sel;
  logic        inc_go;

  assign count      = {word_reg[1], word_reg[0]};
  assign count_next = count + 64'd1;
  assign wr_sel     = {wr_hi, wr_lo};
  assign inc_go     = inc_en && (wr_sel == 2'b00);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_word
      // Each word either takes a direct write or its slice of the incremented count
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          word_reg[gi] <= '0;
        end else if (wr_sel[gi]) begin
          word_reg[gi] <= wr_data;
        end else if (inc_go) begin
          word_reg[gi] <= count_next[gi*32 +: 32];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/rv32im_csr_reg_file.sv
// Machine-mode CSR register file: masked clocked writes, combinational
// read mux, mcycle counter, mstatus and privilege export.
module rv32im_csr_reg_file
  import rv32im_csr_reg_file_pkg::*;
#(
  parameter logic [31:0] HART_ID  = 32'h0,
  parameter logic [31:0] MISA_VAL = 32'h4000_1100
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [CSR_WIDTH-1:0] csr_addr_i,
  input  logic [API_XLEN-1:0]  val_csr_i,
  input  logic                 csr_write_en_i,
  input  logic                 csr_read_en_i,
  output logic [API_XLEN-1:0]  val_csr_o,
  output logic [API_XLEN-1:0]  csr_status_o,
  output logic [1:0]           priviledge_mode_o
);

  xlen_t       mstatus_reg;
  xlen_t       mie_reg;
  xlen_t       mtvec_reg;
  xlen_t       mscratch_reg;
  xlen_t       mepc_reg;
  xlen_t       mcause_reg;
  xlen_t       mtval_reg;
  logic [63:0] mcycle;
  xlen_t       read_data;
  logic        wr_mcycle;
  logic        wr_mcycleh;

  assign wr_mcycle  = csr_write_en_i && (csr_addr_i == CSR_MCYCLE);
  assign wr_mcycleh = csr_write_en_i && (csr_addr_i == CSR_MCYCLEH);

  rv32im_csr_counter64 u_mcycle (
    .clk     (clk_i),
    .rst     (rst_n_i),
    .inc_en  (1'b1),
    .wr_lo   (wr_mcycle),
    .wr_hi   (wr_mcycleh),
    .wr_data (val_csr_i),
    .count   (mcycle)
  );

  // Register bank: addressed register takes the write data through its mask
  always_ff @(posedge clk_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      mstatus_reg  <= MSTATUS_RESET;
      mie_reg      <= '0;
      mtvec_reg    <= '0;
      mscratch_reg <= '0;
      mepc_reg     <= '0;
      mcause_reg   <= '0;
      mtval_reg    <= '0;
    end else if (csr_write_en_i) begin
      case (csr_addr_i)
        CSR_MSTATUS:  mstatus_reg  <= mstatus_warl(val_csr_i);
        CSR_MIE:      mie_reg      <= val_csr_i & MIE_MASK;
        CSR_MTVEC:    mtvec_reg    <= val_csr_i & MTVEC_MASK;
        CSR_MSCRATCH: mscratch_reg <= val_csr_i;
        CSR_MEPC:     mepc_reg     <= val_csr_i & MEPC_MASK;
        CSR_MCAUSE:   mcause_reg   <= val_csr_i;
        CSR_MTVAL:    mtval_reg    <= val_csr_i;
        default:      ;
      endcase
    end
  end

  // Read mux: unimplemented addresses and read-only zero registers return 0
  always_comb begin
    read_data = '0;
    case (csr_addr_i)
      CSR_MSTATUS:  read_data = mstatus_reg;
      CSR_MISA:     read_data = MISA_VAL;
      CSR_MIE:      read_data = mie_reg;
      CSR_MTVEC:    read_data = mtvec_reg;
      CSR_MSCRATCH: read_data = mscratch_reg;
      CSR_MEPC:     read_data = mepc_reg;
      CSR_MCAUSE:   read_data = mcause_reg;
      CSR_MTVAL:    read_data = mtval_reg;
      CSR_MIP:      read_data = '0;
      CSR_MCYCLE,
      CSR_CYCLE:    read_data = mcycle[31:0];
      CSR_MCYCLEH,
      CSR_CYCLEH:   read_data = mcycle[63:32];
      CSR_MHARTID:  read_data = HART_ID;
      default:      read_data = '0;
    endcase
  end

  assign val_csr_o         = csr_read_en_i ? read_data : '0;
  assign csr_status_o      = mstatus_reg;
  assign priviledge_mode_o = PRIV_M;

endmodule

// File: tb/tb_rv32im_csr_reg_file.sv
// Directed bench for rv32im_csr_reg_file: expectations are queued as each
// step is driven and popped/compared once the combinational outputs settle.
module tb_rv32im_csr_reg_file;

  localparam logic [31:0] TB_HART_ID = 32'hCAFE_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic [31:0] status;
  logic [1:0]  priv;

  typedef struct {
    string       tag;
    int          sel;   // 0: val_csr_o, 1: csr_status_o, 2: priviledge_mode_o
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  test_cnt = 0;
  int  fail_cnt = 0;

  logic [63:0] model_cyc;

  rv32im_csr_reg_file #(
    .HART_ID  (TB_HART_ID),
    .MISA_VAL (32'h4000_1100)
  ) dut (
    .clk_i             (clk),
    .rst_n_i           (rst),
    .csr_addr_i        (addr),
    .val_csr_i         (wdata),
    .csr_write_en_i    (we),
    .csr_read_en_i     (re),
    .val_csr_o         (rdata),
    .csr_status_o      (status),
    .priviledge_mode_o (priv)
  );

  always #5 clk = ~clk;

  // Reference mcycle: counts every edge out of reset, word writes replace and hold
  always @(posedge clk) begin
    if (rst)
      model_cyc <= 64'd0;
    else if (we && addr == 12'hB00)
      model_cyc[31:0] <= wdata;
    else if (we && addr == 12'hB80)
      model_cyc[63:32] <= wdata;
    else
      model_cyc <= model_cyc + 64'd1;
  end

  task automatic step(input logic [11:0] a, input logic [31:0] d,
                      input logic w, input logic r);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = w;
    re    = r;
  endtask

  task automatic expect_out(input string tag, input int sel, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check_all();
    sb_t         e;
    logic [31:0] obs;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        0:       obs = rdata;
        1:       obs = status;
        default: obs = {30'b0, priv};
      endcase
      test_cnt++;
      assert (obs === e.exp)
        $display("[TB] %s ok obs=%08h", e.tag, obs);
      else begin
        fail_cnt++;
        $error("FAIL %s observed=%08h expected=%08h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    addr = 12'h300; wdata = '0; we = 1'b0; re = 1'b1;

    // Reset values
    step(12'h300, 32'h0, 1'b0, 1'b1);
    expect_out("rst_mstatus_read", 0, 32'h0000_1800);
    expect_out("rst_status_o",     1, 32'h0000_1800);
    expect_out("rst_priv",         2, 32'h3);
    check_all();
    step(12'hB00, 32'h0, 1'b0, 1'b1);
    expect_out("rst_mcycle", 0, 32'h0);
    check_all();

    @(negedge clk);
    rst = 1'b0;

    // Masked write, MPP WARL, read-before-write in the write cycle
    step(12'h300, 32'hF000_0000, 1'b1, 1'b1);
    expect_out("mstatus_same_cycle", 0, 32'h0000_1800);
    check_all();
    step(12'h300, 32'h0, 1'b0, 1'b1);
    expect_out("mstatus_masked", 0, 32'h0000_1800);
    check_all();
    step(12'h300, 32'h0000_0088, 1'b1, 1'b1);
    check_all();
    step(12'h300, 32'h0, 1'b0, 1'b1);
    expect_out("mstatus_mie_mpie", 0, 32'h0000_1888);
    expect_out("status_o_1888",    1, 32'h0000_1888);
    check_all();

    // Read gating
    step(12'h300, 32'h0, 1'b0, 1'b0);
    expect_out("read_gated",     0, 32'h0);
    expect_out("status_ungated", 1, 32'h0000_1888);
    check_all();

    // Free-running counter against the reference model
    for (int i = 0; i < 5; i++) begin
      step(12'hB00, 32'h0, 1'b0, 1'b1);
      expect_out($sformatf("mcycle_run%0d", i), 0, model_cyc[31:0]);
      check_all();
    end
    step(12'hC00, 32'h0, 1'b0, 1'b1);
    expect_out("cycle_alias", 0, model_cyc[31:0]);
    check_all();
    step(12'hC80, 32'h0, 1'b0, 1'b1);
    expect_out("cycleh_alias", 0, model_cyc[63:32]);
    check_all();

    // Carry from low into high word
    step(12'hB80, 32'h0, 1'b1, 1'b1);
    check_all();
    step(12'hB00, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check_all();
    step(12'hB00, 32'h0, 1'b0, 1'b1);
    expect_out("mcycle_written", 0, 32'hFFFF_FFFF);
    check_all();
    step(12'hB00, 32'h0, 1'b0, 1'b1);
    expect_out("mcycle_carry_lo", 0, 32'h0);
    check_all();
    step(12'hB80, 32'h0, 1'b0, 1'b1);
    expect_out("mcycle_carry_hi", 0, 32'h1);
    check_all();

    // 64-bit wrap
    step(12'hB80, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check_all();
    step(12'hB00, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check_all();
    step(12'hB80, 32'h0, 1'b0, 1'b1);
    expect_out("mcycleh_max", 0, 32'hFFFF_FFFF);
    check_all();
    step(12'hB80, 32'h0, 1'b0, 1'b1);
    expect_out("mcycle_wrap_hi", 0, 32'h0);
    check_all();

    // Read-only and unimplemented addresses
    step(12'h301, 32'h0, 1'b1, 1'b1);
    check_all();
    step(12'h301, 32'h0, 1'b0, 1'b1);
    expect_out("misa_ro", 0, 32'h4000_1100);
    check_all();
    step(12'h7FF, 32'h5, 1'b1, 1'b1);
    check_all();
    step(12'h7FF, 32'h0, 1'b0, 1'b1);
    expect_out("unimpl_7ff", 0, 32'h0);
    check_all();
    step(12'h344, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check_all();
    step(12'h344, 32'h0, 1'b0, 1'b1);
    expect_out("mip_zero", 0, 32'h0);
    check_all();
    step(12'hF14, 32'h0, 1'b0, 1'b1);
    expect_out("mhartid", 0, TB_HART_ID);
    check_all();
    step(12'hF11, 32'h0, 1'b0, 1'b1);
    expect_out("mvendorid", 0, 32'h0);
    check_all();

    // Full-width and masked read/write registers
    step(12'h340, 32'hDEAD_BEEF, 1'b1, 1'b1);
    expect_out("mscratch_prewrite", 0, 32'h0);
    check_all();
    step(12'h340, 32'h0, 1'b0, 1'b1);
    expect_out("mscratch", 0, 32'hDEAD_BEEF);
    check_all();
    step(12'h305, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check_all();
    step(12'h305, 32'h0, 1'b0, 1'b1);
    expect_out("mtvec_mask", 0, 32'hFFFF_FFFC);
    check_all();
    step(12'h341, 32'h1234_5677, 1'b1, 1'b0);
    check_all();
    step(12'h341, 32'h0, 1'b0, 1'b1);
    expect_out("mepc_mask", 0, 32'h1234_5674);
    check_all();
    step(12'h304, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check_all();
    step(12'h304, 32'h0, 1'b0, 1'b1);
    expect_out("mie_mask", 0, 32'h0000_0888);
    check_all();
    step(12'h342, 32'h8000_000B, 1'b1, 1'b0);
    check_all();
    step(12'h342, 32'h0, 1'b0, 1'b1);
    expect_out("mcause", 0, 32'h8000_000B);
    check_all();
    step(12'h343, 32'hA5A5_5A5A, 1'b1, 1'b0);
    check_all();
    step(12'h343, 32'h0, 1'b0, 1'b1);
    expect_out("mtval", 0, 32'hA5A5_5A5A);
    check_all();

    // Asynchronous reset mid-count, observed before any clock edge
    step(12'hB00, 32'h0, 1'b0, 1'b1);
    #1;
    rst = 1'b1;
    expect_out("async_rst_mcycle", 0, 32'h0);
    expect_out("async_rst_status", 1, 32'h0000_1800);
    check_all();
    step(12'h340, 32'h0, 1'b0, 1'b1);
    expect_out("async_rst_mscratch", 0, 32'h0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step(12'hB00, 32'h0, 1'b0, 1'b1);
    expect_out("mcycle_after_rst", 0, model_cyc[31:0]);
    check_all();

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
